// File: rtl/svpwm_ref_sequencer.sv
// svpwm_ref_sequencer: voltage reference (mag, angle) -> sector + dwell times.
// Macro SVPWM_SEQ_SYNC_EN: defined = commit waits for period_start.
module svpwm_ref_sequencer #(
  parameter int unsigned TIMP  = 250,
  parameter int unsigned LUT_W = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        enable,
  input  logic        ref_valid,
  output logic        ref_ready,
  input  logic [7:0]  ref_mag,
  input  logic [10:0] ref_angle,
  input  logic        period_start,
  output logic [3:0]  sektor,
  output logic [7:0]  time_vector1,
  output logic [7:0]  time_vector2,
  output logic        ovm,
  output logic        err_angle,
  output logic        upd_pending
);

  localparam logic [7:0] TIMP_W = 8'(TIMP);
  localparam longint SC   = longint'(1) << 28;
  localparam longint PI_Q = 64'sd843314857;

  // Taylor series for sin(x), x in Q28 radians, elaboration only.
  function automatic longint sin_q(input longint x);
    longint term;
    longint acc;
    term = x;
    acc  = x;
    for (int n = 1; n <= 7; n++) begin
      term = (term * x) / SC;
      term = (term * x) / SC;
      term = -term / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return acc;
  endfunction

  // round(255 * sin(i*60/256 deg) / sin(60 deg))
  function automatic logic [7:0] lut_val(input int i);
    longint s;
    longint s60;
    longint r;
    s   = sin_q(longint'(i) * PI_Q / 768);
    s60 = sin_q(longint'(256) * PI_Q / 768);
    r   = (510 * s + s60) / (2 * s60);
    return r[7:0];
  endfunction

`ifdef SVPWM_SEQ_SYNC_EN
  typedef enum logic [2:0] {
    S_IDLE, S_M1, S_T1, S_M2, S_T2, S_CLP, S_WAIT
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_M1, S_T1, S_M2, S_T2, S_CLP
  } state_e;
`endif

  state_e      state_q;
  logic [2:0]  sec_q;
  logic [7:0]  k_q;
  logic [7:0]  mag_q;
  logic [15:0] p_q;
  logic [7:0]  t1_q;
  logic [7:0]  t2_q;
  logic [3:0]  sektor_q;
  logic [7:0]  tv1_q;
  logic [7:0]  tv2_q;
  logic        ovm_q;
  logic        err_q;
`ifdef SVPWM_SEQ_SYNC_EN
  logic        ovmn_q;
  logic        upd_q;
`endif

  logic [LUT_W-1:0] lut_tab [257];

  for (genvar g = 0; g < 257; g++) begin : g_lut
    localparam logic [7:0] V = lut_val(g);
    assign lut_tab[g] = V;
  end

  logic [8:0]  lut_idx;
  logic [7:0]  lut_out;
  logic [15:0] prod8;
  logic [23:0] prod16;
  logic [8:0]  sum;
  logic        over;
  logic [7:0]  t2_clp;

  // M1 reads the mirrored entry, M2 the direct one: one LUT port.
  assign lut_idx = (state_q == S_M1) ? (9'd256 - {1'b0, k_q})
                                     : {1'b0, k_q};
  assign lut_out = (lut_idx <= 9'd256) ? lut_tab[lut_idx] : '0;

  // Shared product paths: 8x8 in M1/M2, 16x8 in T1/T2.
  assign prod8  = {8'd0, mag_q} * {8'd0, lut_out};
  assign prod16 = {8'd0, p_q} * {16'd0, TIMP_W};

  assign sum    = {1'b0, t1_q} + {1'b0, t2_q};
  assign over   = sum > {1'b0, TIMP_W};
  assign t2_clp = over ? (TIMP_W - t1_q) : t2_q;

  logic unused_lo;
  assign unused_lo = ^prod16[15:0];

  // Sequencer FSM with registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      sec_q    <= '0;
      k_q      <= '0;
      mag_q    <= '0;
      p_q      <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      sektor_q <= '0;
      tv1_q    <= '0;
      tv2_q    <= '0;
      ovm_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef SVPWM_SEQ_SYNC_EN
      ovmn_q   <= 1'b0;
      upd_q    <= 1'b0;
`endif
    end else if (!enable) begin
      state_q  <= S_IDLE;
      sektor_q <= '0;
      tv1_q    <= '0;
      tv2_q    <= '0;
      ovm_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef SVPWM_SEQ_SYNC_EN
      upd_q    <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (ref_valid) begin
            if (ref_angle >= 11'd1536) begin
              err_q <= 1'b1;
            end else begin
              sec_q   <= ref_angle[10:8];
              k_q     <= ref_angle[7:0];
              mag_q   <= ref_mag;
              state_q <= S_M1;
            end
          end
        end
        S_M1: begin
          p_q     <= prod8;
          state_q <= S_T1;
        end
        S_T1: begin
          t1_q    <= prod16[23:16];
          state_q <= S_M2;
        end
        S_M2: begin
          p_q     <= prod8;
          state_q <= S_T2;
        end
        S_T2: begin
          t2_q    <= prod16[23:16];
          state_q <= S_CLP;
        end
`ifdef SVPWM_SEQ_SYNC_EN
        S_CLP: begin
          t2_q    <= t2_clp;
          ovmn_q  <= over;
          upd_q   <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (period_start) begin
            sektor_q <= {1'b0, sec_q};
            tv1_q    <= t1_q;
            tv2_q    <= t2_q;
            ovm_q    <= ovmn_q;
            upd_q    <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
`else
        S_CLP: begin
          sektor_q <= {1'b0, sec_q};
          tv1_q    <= t1_q;
          tv2_q    <= t2_clp;
          ovm_q    <= over;
          state_q  <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ref_ready    = enable && (state_q == S_IDLE);
  assign sektor       = sektor_q;
  assign time_vector1 = tv1_q;
  assign time_vector2 = tv2_q;
  assign ovm          = ovm_q;
  assign err_angle    = err_q;

`ifdef SVPWM_SEQ_SYNC_EN
  assign upd_pending  = upd_q;
`else
  logic unused_ps;
  assign unused_ps    = period_start;
  assign upd_pending  = 1'b0;
`endif

endmodule

// File: doc/svpwm_ref_sequencer.md
Name: svpwm_ref_sequencer

Overview:
Converts a voltage reference (modulation magnitude + electrical angle) into the sector index and two active-vector dwell times consumed by the SVPWM pulse generator (sektor, time_vector1, time_vector2). A single shared multiplier is time-multiplexed by an FSM. Results commit glitch-free on the PWM period boundary, so the generator never sees a half-updated set. Sits between the motor-control reference source and the SVPWM generator.

Parameters:
TIMP, 250, half-period count of generator; must equal generator Timp; legal 16..255
LUT_W, 8, width of sin-ratio LUT entries (fixed 8; parameter for documentation/asserts only)

Ports:
CLK  in  1  single clock, rising edge
RST_N  in  1  asynchronous active-low reset
enable  in  1  1 = run; 0 = force safe outputs, abort calculation
ref_valid  in  1  reference presented
ref_ready  out  1  sequencer accepts reference (transfer when valid&ready at CLK edge)
ref_mag  in  8  modulation index, 0..255 = 0..1.0
ref_angle  in  11  electrical angle, 0..1535 = 0..360 deg (256 counts per 60 deg sector)
period_start  in  1  one-cycle pulse, coincident with generator counter wrap to 0
sektor  out  4  sector 0..5 to generator
time_vector1  out  8  dwell of vector OUT[sektor], counts
time_vector2  out  8  dwell of vector OUT[sektor+1 mod 6], counts
ovm  out  1  registered; 1 = last committed set was overmodulation-clamped
err_angle  out  1  one-cycle pulse: accepted angle >= 1536, discarded
upd_pending  out  1  computed set waiting for period_start

Behaviour:
- Reset (async, RST_N=0): state IDLE; sektor=0, time_vector1=0, time_vector2=0, ovm=0, err_angle=0, upd_pending=0; internal regs 0. ref_ready = enable (combinational from state).
- ref_ready = enable && state==IDLE. No other state accepts a reference.
- Decode at accept: sec=ref_angle[10:8], k=ref_angle[7:0]. If ref_angle>=1536: pulse err_angle next cycle, stay IDLE, outputs unchanged.
- LUT: L(i), i=0..256, = round(255*sin(i*60/256 deg)/sin60); L(0)=0, L(256)=255, L(128)=147. Combinational ROM, 257 entries.
- FSM (one state per cycle): IDLE -> M1 (p=mag*L(256-k), 16b) -> T1 (t1=(p*TIMP)>>16, truncate) -> M2 (p=mag*L(k)) -> T2 (t2 same form) -> CLP -> WAIT -> IDLE.
- CLP: s=t1+t2 (9b). If s>TIMP: t2=TIMP-t1, ovm_next=1; else ovm_next=0. Sets upd_pending=1.
- WAIT: on period_start=1, register sektor=sec, time_vector1=t1, time_vector2=t2, ovm=ovm_next; clear upd_pending; go IDLE. Outputs visible the edge after the period_start edge.
- Latency: accept edge -> WAIT entered 6 edges later; commit at first period_start seen in WAIT. period_start during M1..CLP ignored.
- Shared multiplier: exactly one 8x8 and one 16x8 product path; no duplicated computation.
- enable falls (any state): next edge sektor=0, time_vector1=0, time_vector2=0 (generator then holds all switches off), ovm=0, upd_pending=0, state IDLE; in-flight set discarded.
- Outputs change only at commit or enable=0/reset; never mid-period.

Optional Feature:
SVPWM_SEQ_SYNC_EN: defined -> commit waits in WAIT for period_start as above. Undefined -> WAIT state removed; commit occurs on the CLP edge (outputs updated 6 edges after accept), period_start ignored, upd_pending tied 0.

Test Plan:
- Reset release, enable=1 -> all outputs 0, ref_ready=1 next cycle.
- mag=255, angle=0, period_start after 10 cycles -> sektor=0, t1=248, t2=0, ovm=0; outputs unchanged until the period_start edge.
- mag=128, angle=576 -> sektor=2, t1=101, t2=37, ovm=0.
- mag=255, angle=128 -> raw 142/142, clamped: sektor=0, t1=142, t2=108, ovm=1.
- angle=1536 -> err_angle one-cycle pulse, outputs hold previous set, ref_ready back high next cycle.
- enable dropped while in WAIT with upd_pending=1 -> next edge outputs 0, upd_pending=0, later period_start causes no commit.
